// File: rtl/sm2_mul_pkg.sv
// Shared types and helpers for the SM2 multiplier arbiter.
package sm2_mul_pkg;
  localparam int MUL_W   = 128;
  localparam int MAX_REQ = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  function automatic logic [MAX_REQ-1:0] idx2oh(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester strictly after last_i, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [IW-1:0]   gnt_o,
  output logic            vld_o
);
  int idx;

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    // k runs 1..NREQ so last_i itself has the lowest priority
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_i) + k) % NREQ;
      if (!vld_o && req_i[idx]) begin
        gnt_o = IW'(idx);
        vld_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mul_ko_arb.sv
// Round-robin arbiter/sequencer sharing one Karatsuba multiplier between NREQ units.
module mul_ko_arb
  import sm2_mul_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = MUL_W,
  parameter int CNTW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] a_i,
  input  logic [NREQ*W-1:0] b_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   done_o,
  output logic [2*W-1:0]    r_o,
  output logic              busy_o,
  output logic              mul_vld_o,
  output logic [W-1:0]      mul_a_o,
  output logic [W-1:0]      mul_b_o,
  input  logic              mul_fin_i,
  input  logic [2*W-1:0]    mul_r_i,
  output logic [CNTW-1:0]   op_cnt_o
);
  localparam int IW = $clog2(NREQ);

  state_e            state_q;
  logic [IW-1:0]     owner_q, last_q, gnt;
  logic              gnt_vld;
  logic [NREQ-1:0]   ack_q, done_q;
  logic [2*W-1:0]    r_q;
  logic [W-1:0]      a_q, b_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .gnt_o  (gnt),
    .vld_o  (gnt_vld)
  );

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= '0;
      done_q  <= '0;
      r_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
      last_q  <= IW'(NREQ-1);
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: if (gnt_vld) begin
          a_q     <= a_i[int'(gnt)*W +: W];
          b_q     <= b_i[int'(gnt)*W +: W];
          owner_q <= gnt;
          last_q  <= gnt;
          ack_q   <= NREQ'(idx2oh(int'(gnt)));
          state_q <= ISSUE;
        end
        ISSUE: if (mul_fin_i) begin
          r_q     <= mul_r_i;
          done_q  <= NREQ'(idx2oh(int'(owner_q)));
          cnt_q   <= cnt_d;
          state_q <= DONE;
        end
        // one guaranteed idle edge for the multiplier before the next grant
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // valid drops in the fin cycle so the multiplier never sees a second start
  assign mul_vld_o = (state_q == ISSUE) && !mul_fin_i;
  assign busy_o    = (state_q != IDLE);
  assign ack_o     = ack_q;
  assign done_o    = done_q;
  assign r_o       = r_q;
  assign mul_a_o   = a_q;
  assign mul_b_o   = b_q;
  assign op_cnt_o  = cnt_q;
endmodule

// File: tb/tb_mul_ko_arb.sv
// Bench for mul_ko_arb with a behavioural multiplier and an expected-result queue.
module tb_mul_ko_arb;
  localparam int NREQ = 2, W = 128, CNTW = 32, LAT = 5;

  logic              clk = 1'b0, rst;
  logic [NREQ-1:0]   req_i, ack_o, done_o;
  logic [NREQ*W-1:0] a_i, b_i;
  logic [2*W-1:0]    r_o, mul_r_i;
  logic              busy_o, mul_vld_o, mul_fin_i;
  logic [W-1:0]      mul_a_o, mul_b_o;
  logic [CNTW-1:0]   op_cnt_o;

  int total = 0, bad = 0;

  typedef struct packed {
    logic [NREQ-1:0] oh;
    logic [2*W-1:0]  r;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mul_ko_arb #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .ack_o(ack_o), .done_o(done_o), .r_o(r_o), .busy_o(busy_o),
    .mul_vld_o(mul_vld_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_fin_i(mul_fin_i), .mul_r_i(mul_r_i), .op_cnt_o(op_cnt_o)
  );

  // Behavioural multiplier: LAT edges from first sampled valid to sampled fin
  logic m_run, m_fin, fin_force;
  int m_cnt;
  logic [W-1:0] m_a, m_b;
  logic [2*W-1:0] m_r;
  assign mul_fin_i = m_fin | fin_force;
  assign mul_r_i   = m_r;
  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_fin <= 1'b0; m_cnt <= 0; m_r <= '0;
    end else if (m_fin) begin
      m_fin <= 1'b0; m_run <= 1'b0;
    end else if (!m_run && mul_vld_o) begin
      m_run <= 1'b1; m_cnt <= LAT-1; m_a <= mul_a_o; m_b <= mul_b_o;
    end else if (m_run) begin
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else begin
        m_fin <= 1'b1;
        m_r   <= {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
      end
    end
  end

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] aa, bb;
    aa = {{W{1'b0}}, a};
    bb = {{W{1'b0}}, b};
    return aa * bb;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for a done pulse; withdraws each request when it is acked.
  task automatic wait_done(input int budget, output logic [NREQ-1:0] d,
                           output logic [2*W-1:0] r, output int cyc,
                           output logic [NREQ-1:0] ack_seen, output bit to);
    to = 1'b1; d = '0; r = '0; cyc = 0; ack_seen = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc = i + 1;
      if (ack_o != '0) ack_seen = ack_o;
      req_i = req_i & ~ack_o;
      if (done_o != '0) begin
        d = done_o; r = r_o; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req_i = '0; a_i = '0; b_i = '0; fin_force = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mul_vld_o !== 1'b0) begin bad++; $display("FAIL reset_vld_during: got %b exp 0", mul_vld_o); end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ack_o, done_o, busy_o, mul_vld_o} !== '0 || r_o !== '0 || mul_a_o !== '0 ||
        mul_b_o !== '0 || op_cnt_o !== '0) begin
      bad++;
      $display("FAIL reset_state: ack=%b done=%b busy=%b vld=%b r=%h a=%h b=%h cnt=%0d exp all zero",
               ack_o, done_o, busy_o, mul_vld_o, r_o, mul_a_o, mul_b_o, op_cnt_o);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] d, acks; logic [2*W-1:0] r; int cyc; bit to; exp_t e;
    do_reset();
    a_i[0 +: W] = 128'h3; b_i[0 +: W] = 128'h5;
    req_i = 2'b01;
    exp_q.push_back('{2'b01, 256'hF});
    @(negedge clk);
    total++;
    if (ack_o !== 2'b01 || mul_vld_o !== 1'b1) begin
      bad++; $display("FAIL single_ack: ack=%b vld=%b exp ack=01 vld=1", ack_o, mul_vld_o);
    end
    req_i = '0;
    wait_done(100, d, r, cyc, acks, to);
    e = exp_q.pop_front();
    total++;
    if (to || d !== e.oh || r !== e.r) begin
      bad++; $display("FAIL single_done: done=%b r=%h timeout=%0d exp done=%b r=%h", d, r, to, e.oh, e.r);
    end
    total++;
    if (op_cnt_o !== 32'd1) begin bad++; $display("FAIL single_cnt: got %0d exp 1", op_cnt_o); end
    @(negedge clk);
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL single_busy: got %b exp 0", busy_o); end
  endtask

  task automatic test_simultaneous();
    logic [NREQ-1:0] d, acks; logic [2*W-1:0] r; int cyc; bit to; exp_t e;
    do_reset();
    a_i = {128'h1_0000_0000, {W{1'b1}}};
    b_i = {128'hFFFF, {W{1'b1}}};
    req_i = 2'b11;
    exp_q.push_back('{2'b01, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001});
    exp_q.push_back('{2'b10, 256'hFFFF_0000_0000});
    @(negedge clk);
    total++;
    if (ack_o !== 2'b01) begin bad++; $display("FAIL simul_first_grant: got %b exp 01", ack_o); end
    req_i[0] = 1'b0;
    wait_done(100, d, r, cyc, acks, to);
    e = exp_q.pop_front();
    total++;
    if (to || d !== e.oh || r !== e.r) begin
      bad++; $display("FAIL simul_done0: done=%b r=%h timeout=%0d exp done=%b r=%h", d, r, to, e.oh, e.r);
    end
    wait_done(100, d, r, cyc, acks, to);
    e = exp_q.pop_front();
    total++;
    if (to || d !== e.oh || r !== e.r || acks !== 2'b10) begin
      bad++; $display("FAIL simul_done1: done=%b r=%h ack=%b timeout=%0d exp done=%b r=%h ack=10",
                      d, r, acks, to, e.oh, e.r);
    end
    total++;
    if (cyc !== LAT + 3) begin bad++; $display("FAIL simul_spacing: got %0d exp %0d", cyc, LAT + 3); end
  endtask

  task automatic test_fairness();
    logic [W-1:0] fa[NREQ][4], fb[NREQ][4];
    int nxt[NREQ];
    int served, grants, k;
    exp_t e;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      nxt[i] = 0;
      for (int j = 0; j < 4; j++) begin fa[i][j] = rnd128(); fb[i][j] = rnd128(); end
      a_i[i*W +: W] = fa[i][0]; b_i[i*W +: W] = fb[i][0];
    end
    for (int j = 0; j < 8; j++)
      exp_q.push_back('{NREQ'(1) << (j % 2), ref_mul(fa[j%2][j/2], fb[j%2][j/2])});
    req_i = 2'b11;
    served = 0; grants = 0;
    for (int c = 0; c < 400 && served < 8; c++) begin
      @(negedge clk);
      if (ack_o != '0) begin
        total++;
        if (ack_o !== (NREQ'(1) << (grants % 2))) begin
          bad++; $display("FAIL fair_grant%0d: got %b exp %b", grants, ack_o, NREQ'(1) << (grants % 2));
        end
        grants++;
        k = ack_o[1] ? 1 : 0;
        nxt[k]++;
        if (nxt[k] < 4) begin a_i[k*W +: W] = fa[k][nxt[k]]; b_i[k*W +: W] = fb[k][nxt[k]]; end
        else req_i[k] = 1'b0;
      end
      if (done_o != '0) begin
        e = exp_q.pop_front();
        total++;
        if (done_o !== e.oh || r_o !== e.r) begin
          bad++; $display("FAIL fair_done%0d: done=%b r=%h exp done=%b r=%h", served, done_o, r_o, e.oh, e.r);
        end
        served++;
      end
    end
    total++;
    if (served != 8 || op_cnt_o !== 32'd8) begin
      bad++; $display("FAIL fair_count: served=%0d cnt=%0d exp 8/8", served, op_cnt_o);
    end
    req_i = '0;
  endtask

  task automatic test_handshake();
    logic [W-1:0] ha, hb;
    bit stab_err, fin_err, done_err, saw_fin, got_done;
    exp_t e;
    do_reset();
    ha = rnd128(); hb = rnd128();
    a_i[0 +: W] = ha; b_i[0 +: W] = hb;
    exp_q.push_back('{2'b01, ref_mul(ha, hb)});
    req_i = 2'b01;
    stab_err = 0; fin_err = 0; done_err = 0; saw_fin = 0; got_done = 0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      @(negedge clk);
      if (ack_o[0]) begin
        req_i = '0;
        a_i[0 +: W] = ~ha; b_i[0 +: W] = ~hb;
      end
      if (mul_vld_o && (mul_a_o !== ha || mul_b_o !== hb)) stab_err = 1;
      if (mul_fin_i) begin saw_fin = 1; if (mul_vld_o !== 1'b0) fin_err = 1; end
      if (done_o != '0) begin
        got_done = 1;
        if (mul_vld_o !== 1'b0) done_err = 1;
        e = exp_q.pop_front();
        total++;
        if (done_o !== e.oh || r_o !== e.r) begin
          bad++; $display("FAIL hs_done: done=%b r=%h exp done=%b r=%h", done_o, r_o, e.oh, e.r);
        end
      end
    end
    total++;
    if (stab_err || !got_done) begin bad++; $display("FAIL hs_operand_stable: err=%0d done=%0d exp 0/1", stab_err, got_done); end
    total++;
    if (fin_err || !saw_fin) begin bad++; $display("FAIL hs_vld_fin: err=%0d saw_fin=%0d exp 0/1", fin_err, saw_fin); end
    total++;
    if (done_err) begin bad++; $display("FAIL hs_vld_done: vld high in DONE, exp low"); end
  endtask

  task automatic test_spurious_fin();
    logic [CNTW-1:0] c0;
    bit err;
    @(negedge clk);
    c0 = op_cnt_o; err = 0;
    fin_force = 1'b1;
    @(negedge clk);
    fin_force = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_o !== '0 || busy_o !== 1'b0) err = 1;
    end
    total++;
    if (err || op_cnt_o !== c0) begin
      bad++; $display("FAIL spurious_fin: err=%0d cnt=%0d exp err=0 cnt=%0d", err, op_cnt_o, c0);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [NREQ-1:0] d, acks; logic [2*W-1:0] r; int cyc; bit to; exp_t e;
    bit err;
    do_reset();
    a_i[0 +: W] = rnd128(); b_i[0 +: W] = rnd128();
    req_i = 2'b01;
    @(negedge clk);
    req_i = '0;
    repeat (2) @(negedge clk);
    total++;
    if (busy_o !== 1'b1 || mul_vld_o !== 1'b1) begin
      bad++; $display("FAIL midrst_in_issue: busy=%b vld=%b exp 1/1", busy_o, mul_vld_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ack_o, done_o, busy_o, mul_vld_o} !== '0 || r_o !== '0 || mul_a_o !== '0 ||
        mul_b_o !== '0 || op_cnt_o !== '0) begin
      bad++;
      $display("FAIL midrst_state: ack=%b done=%b busy=%b vld=%b r=%h a=%h cnt=%0d exp all zero",
               ack_o, done_o, busy_o, mul_vld_o, r_o, mul_a_o, op_cnt_o);
    end
    err = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done_o !== '0) err = 1;
    end
    total++;
    if (err) begin bad++; $display("FAIL midrst_no_done: done seen for aborted op, exp none"); end
    a_i[0 +: W] = 128'd7; b_i[0 +: W] = 128'd9;
    exp_q.push_back('{2'b01, 256'd63});
    req_i = 2'b01;
    wait_done(100, d, r, cyc, acks, to);
    e = exp_q.pop_front();
    total++;
    if (to || d !== e.oh || r !== e.r || op_cnt_o !== 32'd1) begin
      bad++; $display("FAIL midrst_after: done=%b r=%h cnt=%0d timeout=%0d exp done=%b r=%h cnt=1",
                      d, r, op_cnt_o, to, e.oh, e.r);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty: %0d left exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_handshake();
    test_spurious_fin();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
